// File: rtl/tilexy_link_fifo_if.sv
// rtl/tilexy_link_fifo_if.sv - inject, link and eject handshake bundle for one mesh tile
// Ports (slave = tile side):
//   in_en/in_datum/in_addr/in_size, wrt_stall          local inject strobe and back-pressure
//   lnk_in_vld/lnk_in_flit/lnk_in_rdy                  flits arriving from neighbours [0]=lower [1]=higher
//   lnk_out_vld/lnk_out_flit/lnk_out_rdy               flits leaving toward neighbours [0]=lower [1]=higher
//   ej_vld/ej_data/ej_addr/ej_size/ej_rdy              local eject head and pop
interface tilexy_link_fifo_if #(
  parameter int DW = 528,
  parameter int AW = 33
);
  localparam int FW = DW + AW + 22;

  logic              in_en;
  logic [DW-1:0]     in_datum;
  logic [AW+9:0]     in_addr;
  logic [11:0]       in_size;
  logic              wrt_stall;

  logic [1:0]        lnk_in_vld;
  logic [2*FW-1:0]   lnk_in_flit;
  logic [1:0]        lnk_in_rdy;

  logic [1:0]        lnk_out_vld;
  logic [2*FW-1:0]   lnk_out_flit;
  logic [1:0]        lnk_out_rdy;

  logic              ej_vld;
  logic [DW-1:0]     ej_data;
  logic [AW+9:0]     ej_addr;
  logic [11:0]       ej_size;
  logic              ej_rdy;

  modport master (
    output in_en, in_datum, in_addr, in_size, lnk_in_vld, lnk_in_flit, lnk_out_rdy, ej_rdy,
    input  wrt_stall, lnk_in_rdy, lnk_out_vld, lnk_out_flit, ej_vld, ej_data, ej_addr, ej_size
  );

  modport slave (
    input  in_en, in_datum, in_addr, in_size, lnk_in_vld, lnk_in_flit, lnk_out_rdy, ej_rdy,
    output wrt_stall, lnk_in_rdy, lnk_out_vld, lnk_out_flit, ej_vld, ej_data, ej_addr, ej_size
  );
endinterface

// File: rtl/tilexy_link_fifo.sv
// rtl/tilexy_link_fifo.sv - one-dimension mesh router stage with transit and eject FIFOs
// Ports:
//   clk_i      single clock
//   rst_ni     asynchronous active-low reset
//   lnk_if     slave side of tilexy_link_fifo_if (inject, two links in, two links out, eject)
//   occ_o      occupancy {eject, transit1, transit0}
//   ovf_err_o  sticky: dropped inject strobe or direction-reversing flit
module tilexy_link_fifo #(
  parameter int TILE_X = 0,
  parameter int TILE_Y = 0,
  parameter int DIM    = 0,
  parameter int DW     = 528,
  parameter int AW     = 33,
  parameter int DEPTH  = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  tilexy_link_fifo_if.slave              lnk_if,
  output logic [3*($clog2(DEPTH)+1)-1:0] occ_o,
  output logic                           ovf_err_o
);
  localparam int FW = DW + AW + 22;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] OWN = (DIM != 0) ? 5'(TILE_Y) : 5'(TILE_X);

  // Flit layout {sz, addr, ty, tx, data}
  function automatic logic [4:0] dest_of(input logic [FW-1:0] f);
    return (DIM != 0) ? f[DW+9:DW+5] : f[DW+4:DW];
  endfunction

  // Two-way round robin, p names the requester with priority
  function automatic logic [1:0] rr2(input logic [1:0] r, input logic p);
    if (p) return r[1] ? 2'b10 : {1'b0, r[0]};
    else   return r[0] ? 2'b01 : {r[1], 1'b0};
  endfunction

  // Three-way round robin: link0, link1, hold
  function automatic logic [2:0] rr3(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] g;
    g = 3'b000;
    case (p)
      2'd1:    g = r[1] ? 3'b010 : r[2] ? 3'b100 : r[0] ? 3'b001 : 3'b000;
      2'd2:    g = r[2] ? 3'b100 : r[0] ? 3'b001 : r[1] ? 3'b010 : 3'b000;
      default: g = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    endcase
    return g;
  endfunction

  // FIFO index: 0 = transit0, 1 = transit1, 2 = eject
  logic [FW-1:0] mem_q [3][DEPTH];
  logic [PW-1:0] wr_q [3], wr_d [3], rd_q [3], rd_d [3];
  logic [CW-1:0] cnt_q [3], cnt_d [3];
  logic          hold_vld_q, hold_vld_d;
  logic [FW-1:0] hold_flit_q, hold_flit_d;
  logic [1:0]    ej_rr_q, ej_rr_d;
  logic          t0_rr_q, t0_rr_d, t1_rr_q, t1_rr_d;
  logic          ovf_q, ovf_d;

  logic [FW-1:0] in_flit [2];
  logic [4:0]    dst0, dst1, dsth;
  logic          l0_ej, l0_tr, l0_bad, l1_ej, l1_tr, l1_bad, h_ej, h_t0, h_t1;
  logic [2:0]    full, empty, push, pop, ej_req, ej_gnt;
  logic [1:0]    t0_req, t0_gnt, t1_req, t1_gnt;
  logic [FW-1:0] push_flit [3];
  logic          hold_load, hold_pop;

  assign in_flit[0] = lnk_if.lnk_in_flit[FW-1:0];
  assign in_flit[1] = lnk_if.lnk_in_flit[2*FW-1:FW];
  assign dst0 = dest_of(in_flit[0]);
  assign dst1 = dest_of(in_flit[1]);
  assign dsth = dest_of(hold_flit_q);

  // A link flit keeps its direction; one that would turn back is a bad flit
  assign l0_ej  = lnk_if.lnk_in_vld[0] & (dst0 == OWN);
  assign l0_tr  = lnk_if.lnk_in_vld[0] & (dst0 >  OWN);
  assign l0_bad = lnk_if.lnk_in_vld[0] & (dst0 <  OWN);
  assign l1_ej  = lnk_if.lnk_in_vld[1] & (dst1 == OWN);
  assign l1_tr  = lnk_if.lnk_in_vld[1] & (dst1 <  OWN);
  assign l1_bad = lnk_if.lnk_in_vld[1] & (dst1 >  OWN);
  assign h_ej   = hold_vld_q & (dsth == OWN);
  assign h_t1   = hold_vld_q & (dsth >  OWN);
  assign h_t0   = hold_vld_q & (dsth <  OWN);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      full[i]  = cnt_q[i][PW];
      empty[i] = (cnt_q[i] == '0);
    end
  end

  // Fullness uses the registered count, so a same-cycle pop never frees a slot
  assign ej_req = {h_ej, l1_ej, l0_ej} & {3{~full[2]}};
  assign t1_req = {h_t1, l0_tr} & {2{~full[1]}};
  assign t0_req = {h_t0, l1_tr} & {2{~full[0]}};
  assign ej_gnt = rr3(ej_req, ej_rr_q);
  assign t1_gnt = rr2(t1_req, t1_rr_q);
  assign t0_gnt = rr2(t0_req, t0_rr_q);

  assign push = {|ej_gnt, |t1_gnt, |t0_gnt};
  assign pop  = {~empty[2] & lnk_if.ej_rdy,
                 ~empty[1] & lnk_if.lnk_out_rdy[1],
                 ~empty[0] & lnk_if.lnk_out_rdy[0]};

  always_comb begin
    push_flit[0] = t0_gnt[0] ? in_flit[1] : hold_flit_q;
    push_flit[1] = t1_gnt[0] ? in_flit[0] : hold_flit_q;
    push_flit[2] = ej_gnt[0] ? in_flit[0] : ej_gnt[1] ? in_flit[1] : hold_flit_q;
  end

  assign hold_load = lnk_if.in_en & ~hold_vld_q;
  assign hold_pop  = ej_gnt[2] | t1_gnt[1] | t0_gnt[1];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      wr_d[i]  = wr_q[i] + PW'(push[i]);
      rd_d[i]  = rd_q[i] + PW'(pop[i]);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    ej_rr_d = ej_rr_q;
    if      (ej_gnt[0]) ej_rr_d = 2'd1;
    else if (ej_gnt[1]) ej_rr_d = 2'd2;
    else if (ej_gnt[2]) ej_rr_d = 2'd0;
    t1_rr_d = t1_gnt[0] ? 1'b1 : t1_gnt[1] ? 1'b0 : t1_rr_q;
    t0_rr_d = t0_gnt[0] ? 1'b1 : t0_gnt[1] ? 1'b0 : t0_rr_q;
    hold_vld_d  = hold_load | (hold_vld_q & ~hold_pop);
    hold_flit_d = hold_load ? {lnk_if.in_size, lnk_if.in_addr[AW-1:0],
                               lnk_if.in_addr[AW+9:AW], lnk_if.in_datum} : hold_flit_q;
    ovf_d = ovf_q | (lnk_if.in_en & hold_vld_q) | l0_bad | l1_bad;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      hold_vld_q  <= 1'b0;
      hold_flit_q <= '0;
      ej_rr_q     <= 2'd0;
      t1_rr_q     <= 1'b0;
      t0_rr_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      hold_vld_q  <= hold_vld_d;
      hold_flit_q <= hold_flit_d;
      ej_rr_q     <= ej_rr_d;
      t1_rr_q     <= t1_rr_d;
      t0_rr_q     <= t0_rr_d;
      ovf_q       <= ovf_d;
    end
  end

  // Data RAM carries no reset
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wr_q[i]] <= push_flit[i];
    end
  end

  assign lnk_if.wrt_stall    = hold_vld_q;
  // Bad flits are still acknowledged so the sender is not blocked
  assign lnk_if.lnk_in_rdy   = {2{rst_ni}} & {l1_bad | ej_gnt[1] | t0_gnt[0],
                                              l0_bad | ej_gnt[0] | t1_gnt[0]};
  assign lnk_if.lnk_out_vld  = ~empty[1:0];
  assign lnk_if.lnk_out_flit = {mem_q[1][rd_q[1]], mem_q[0][rd_q[0]]};
  assign lnk_if.ej_vld       = ~empty[2];
  assign lnk_if.ej_data      = mem_q[2][rd_q[2]][DW-1:0];
  assign lnk_if.ej_addr      = {5'(TILE_Y), 5'(TILE_X), mem_q[2][rd_q[2]][DW+10 +: AW]};
  assign lnk_if.ej_size      = mem_q[2][rd_q[2]][FW-1 -: 12];
  assign occ_o               = {cnt_q[2], cnt_q[1], cnt_q[0]};
  assign ovf_err_o           = ovf_q;
endmodule

// File: tb/tb_tilexy_link_fifo.sv
// tb/tb_tilexy_link_fifo.sv - directed self-checking bench for tilexy_link_fifo
module tb_tilexy_link_fifo;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 4;
  localparam int TX = 3;
  localparam int TY = 2;
  localparam int FW = DW + AW + 22;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tilexy_link_fifo_if #(.DW(DW), .AW(AW)) bus ();
  logic [3*CW-1:0] occ;
  logic            ovf;

  tilexy_link_fifo #(
    .TILE_X(TX), .TILE_Y(TY), .DIM(0), .DW(DW), .AW(AW), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .lnk_if(bus), .occ_o(occ), .ovf_err_o(ovf)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [11:0] sz, input logic [AW-1:0] a,
                                      input logic [4:0] ty, input logic [4:0] tx,
                                      input logic [DW-1:0] d);
    return {sz, a, ty, tx, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [FW-1:0] f;
  logic [DW-1:0] exp_ej [4];

  initial begin
    bus.in_en = 0; bus.in_datum = '0; bus.in_addr = '0; bus.in_size = '0;
    bus.lnk_in_vld = 2'b11; bus.lnk_in_flit = {mk(0, 1, 0, 3, 1), mk(0, 2, 0, 3, 2)};
    bus.lnk_out_rdy = 0; bus.ej_rdy = 0;

    // Reset state, with link valids asserted
    #12;
    check("rst_occ", occ, 0);
    check("rst_stall", bus.wrt_stall, 0);
    check("rst_out_vld", bus.lnk_out_vld, 0);
    check("rst_ej_vld", bus.ej_vld, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_rdy", bus.lnk_in_rdy, 0);
    bus.lnk_in_vld = 0;
    step();
    rst_n = 1;

    // Inject tx=5 -> transit1 two edges later
    f = mk(12'h123, 8'h5A, 5'd2, 5'd5, 16'hBEEF);
    bus.in_size = 12'h123; bus.in_addr = {5'd2, 5'd5, 8'h5A}; bus.in_datum = 16'hBEEF;
    bus.in_en = 1;
    #1; check("inj_stall0", bus.wrt_stall, 0);
    step();
    bus.in_en = 0;
    #1; check("inj_stall1", bus.wrt_stall, 1); check("inj_vld_early", bus.lnk_out_vld, 0);
    step();
    #1;
    check("inj_out_vld", bus.lnk_out_vld, 2'b10);
    check("inj_out_flit", bus.lnk_out_flit[2*FW-1:FW], f);
    check("inj_occ_t1", occ[2*CW-1:CW], 1);
    check("inj_stall_drop", bus.wrt_stall, 0);
    step();
    #1; check("inj_occ_hold", occ[2*CW-1:CW], 1);
    bus.lnk_out_rdy = 2'b10;
    step();
    bus.lnk_out_rdy = 0;
    #1; check("inj_occ_pop", occ[2*CW-1:CW], 0); check("inj_vld_pop", bus.lnk_out_vld, 0);

    // Link0 tx=3 -> eject next cycle
    bus.lnk_in_vld = 2'b01;
    bus.lnk_in_flit = {mk(0, 0, 0, 0, 0), mk(12'hABC, 8'h77, 5'd9, 5'd3, 16'h1234)};
    #1; check("ej_in_rdy", bus.lnk_in_rdy, 2'b01);
    step();
    bus.lnk_in_vld = 0;
    #1;
    check("ej_vld", bus.ej_vld, 1);
    check("ej_addr", bus.ej_addr, {5'd2, 5'd3, 8'h77});
    check("ej_data", bus.ej_data, 16'h1234);
    check("ej_size", bus.ej_size, 12'hABC);
    check("ej_occ", occ[3*CW-1:2*CW], 1);
    bus.ej_rdy = 1;
    step();
    bus.ej_rdy = 0;
    #1; check("ej_occ_pop", occ[3*CW-1:2*CW], 0); check("ej_vld_pop", bus.ej_vld, 0);

    // Fill transit1 to DEPTH from link0, then one more is refused
    for (int i = 0; i < DEPTH; i++) begin
      bus.lnk_in_vld = 2'b01;
      bus.lnk_in_flit = {mk(0, 0, 0, 0, 0), mk(0, 8'(i), 0, 5'd7, 16'h0A00 + 16'(i))};
      #1; check("full_fill_rdy", bus.lnk_in_rdy, 2'b01);
      step();
    end
    bus.lnk_in_flit = {mk(0, 0, 0, 0, 0), mk(0, 8'hFF, 0, 5'd7, 16'h0AFF)};
    #1;
    check("full_occ_t1", occ[2*CW-1:CW], DEPTH);
    check("full_rdy", bus.lnk_in_rdy, 2'b00);
    bus.lnk_in_vld = 0;
    bus.lnk_out_rdy = 2'b10;
    for (int i = 0; i < DEPTH; i++) begin
      check("full_drain_data", bus.lnk_out_flit[FW+DW-1:FW], 16'h0A00 + 16'(i));
      step();
    end
    bus.lnk_out_rdy = 0;
    #1; check("full_drain_occ", occ[2*CW-1:CW], 0);

    // Eject arbitration: link0, link1, inject in turn
    rst_n = 0; #1; rst_n = 1;
    bus.in_en = 1; bus.in_addr = {5'd0, 5'd3, 8'h33}; bus.in_datum = 16'h00CC; bus.in_size = 0;
    bus.lnk_in_vld = 2'b11;
    bus.lnk_in_flit = {mk(0, 0, 0, 3, 16'h00B0), mk(0, 0, 0, 3, 16'h00A0)};
    #1; check("arb_c0_rdy", bus.lnk_in_rdy, 2'b01);
    step();
    bus.in_en = 0;
    bus.lnk_in_flit = {mk(0, 0, 0, 3, 16'h00B0), mk(0, 0, 0, 3, 16'h00A1)};
    #1; check("arb_c1_rdy", bus.lnk_in_rdy, 2'b10); check("arb_c1_stall", bus.wrt_stall, 1);
    step();
    bus.lnk_in_flit = {mk(0, 0, 0, 3, 16'h00B1), mk(0, 0, 0, 3, 16'h00A1)};
    #1; check("arb_c2_rdy", bus.lnk_in_rdy, 2'b00); check("arb_c2_stall", bus.wrt_stall, 1);
    step();
    #1; check("arb_c3_rdy", bus.lnk_in_rdy, 2'b01); check("arb_c3_stall", bus.wrt_stall, 0);
    step();
    bus.lnk_in_vld = 2'b10;
    #1; check("arb_full_occ", occ[3*CW-1:2*CW], DEPTH); check("arb_full_rdy", bus.lnk_in_rdy, 2'b00);
    bus.lnk_in_vld = 0;
    bus.ej_rdy = 1;
    exp_ej[0] = 16'h00A0; exp_ej[1] = 16'h00B0; exp_ej[2] = 16'h00CC; exp_ej[3] = 16'h00A1;
    for (int i = 0; i < 4; i++) begin
      check("arb_order", bus.ej_data, exp_ej[i]);
      step();
    end
    bus.ej_rdy = 0;
    #1; check("arb_empty", bus.ej_vld, 0);

    // Double inject drops the second; reversing link1 flit is acked and discarded
    check("ovf_clear", ovf, 0);
    bus.in_en = 1; bus.in_addr = {5'd0, 5'd5, 8'h11}; bus.in_datum = 16'h1111;
    #1; step();
    bus.in_datum = 16'h2222;
    #1; check("dbl_stall", bus.wrt_stall, 1);
    step();
    bus.in_en = 0;
    #1;
    check("dbl_ovf", ovf, 1);
    check("dbl_out_vld", bus.lnk_out_vld, 2'b10);
    check("dbl_first_kept", bus.lnk_out_flit[FW+DW-1:FW], 16'h1111);
    check("dbl_stall_drop", bus.wrt_stall, 0);
    bus.lnk_out_rdy = 2'b10;
    step();
    bus.lnk_out_rdy = 0;
    bus.lnk_in_vld = 2'b10;
    bus.lnk_in_flit = {mk(0, 0, 0, 5'd6, 16'h6666), mk(0, 0, 0, 0, 0)};
    #1; check("rev_ack", bus.lnk_in_rdy, 2'b10);
    step();
    bus.lnk_in_flit = {mk(0, 0, 0, 5'd1, 16'h0101), mk(0, 0, 0, 0, 0)};
    #1; check("l1_west_rdy", bus.lnk_in_rdy, 2'b10);
    step();
    bus.lnk_in_vld = 0;
    #1;
    check("rev_ovf_sticky", ovf, 1);
    check("l1_west_occ", occ, 9'b000_000_001);
    check("l1_west_vld", bus.lnk_out_vld, 2'b01);
    check("l1_west_data", bus.lnk_out_flit[DW-1:0], 16'h0101);
    bus.lnk_out_rdy = 2'b01;
    step();
    bus.lnk_out_rdy = 0;

    // Wrap: stream 3*DEPTH flits through eject
    bus.ej_rdy = 1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      bus.lnk_in_vld = 2'b01;
      bus.lnk_in_flit = {mk(0, 0, 0, 0, 0), mk(0, 8'(i), 0, 5'd3, 16'h0100 + 16'(i))};
      #1;
      check("wrap_rdy", bus.lnk_in_rdy, 2'b01);
      if (i > 0) check("wrap_data", bus.ej_data, 16'h0100 + 16'(i - 1));
      step();
    end
    bus.lnk_in_vld = 0;
    #1;
    check("wrap_last", bus.ej_data, 16'h0100 + 16'(3 * DEPTH - 1));
    check("wrap_occ", occ[3*CW-1:2*CW], 1);
    step();
    bus.ej_rdy = 0;
    #1; check("wrap_occ0", occ, 0);

    // Asynchronous reset with flits stored
    bus.lnk_in_vld = 2'b01;
    bus.lnk_in_flit = {mk(0, 0, 0, 0, 0), mk(0, 0, 0, 5'd7, 16'h0777)};
    step(); step();
    bus.lnk_in_vld = 0;
    #1; check("ar_occ_pre", occ[2*CW-1:CW], 2);
    #2; rst_n = 0;
    #1;
    check("ar_occ", occ, 0);
    check("ar_out_vld", bus.lnk_out_vld, 0);
    check("ar_ej_vld", bus.ej_vld, 0);
    check("ar_ovf", ovf, 0);
    step();
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/tilexy_link_fifo.md
TILEXY_LINK_FIFO -- requirements
Module: tilexy_link_fifo

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- TILE_X, 0: this tile's X coordinate, 5 bits.
- TILE_Y, 0: this tile's Y coordinate, 5 bits.
- DIM, 0: routing dimension; 0 compares TX, 1 compares TY.
- DW, 528: payload width.
- AW, 33: tile-local address width.
- DEPTH, 8: entries per FIFO; a power of 2, at least 2.
REQ-002 Flit = {sz[11:0], addr[AW-1:0], ty[4:0], tx[4:0], data[DW-1:0]}; FW = DW+AW+22.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock.
- rst, in, 1: reset, asynchronous assert, active-low.
- in_en, in, 1: local inject strobe.
- in_datum, in, DW: inject payload.
- in_addr, in, AW+10: inject address {ty,tx,addr}.
- in_size, in, 12: inject size {shared,exclusive,phymsk}.
- wrt_stall, out, 1: inject holding register occupied.
- lnk_in_vld, in, 2: incoming flit valid; index 0 arrives from the lower-coordinate neighbour, index 1 from the higher.
- lnk_in_flit, in, 2*FW: incoming flits.
- lnk_in_rdy, out, 2: incoming flit accepted.
- lnk_out_vld, out, 2: outgoing flit valid; index 0 goes toward lower coordinates, index 1 toward higher.
- lnk_out_flit, out, 2*FW: outgoing flits.
- lnk_out_rdy, in, 2: neighbour accepts.
- ej_vld, out, 1: eject head valid.
- ej_data, out, DW: eject payload.
- ej_addr, out, AW+10: eject address {TILE_Y,TILE_X,addr}.
- ej_size, out, 12: eject size.
- ej_rdy, in, 1: consumer pops the eject head.
- occ, out, 3*($clog2(DEPTH)+1): occupancy {eject, transit1, transit0}.
- ovf_err, out, 1: sticky error.

Function
REQ-010 Storage: transit FIFO 0 and transit FIFO 1, one per output direction, plus one eject FIFO. Each is DEPTH entries, circular, with separate read and write pointers and a count.
REQ-011 Key: dest = DIM ? ty : tx. dest > own coordinate routes to direction 1; dest < own routes to direction 0; dest == own routes to eject.
REQ-012 Inject:
- A strobe with wrt_stall=0 loads the holding register on the next edge; wrt_stall rises that same edge.
- A strobe while wrt_stall=1 is dropped and sets ovf_err.
REQ-013 Holding-register drain: it pushes into the FIFO selected by REQ-011, gated by REQ-015 and REQ-016. It empties at the edge of its push, so wrt_stall drops the cycle after that push.
REQ-014 Incoming flit on link d:
- dest == own: pushes to eject.
- Otherwise it keeps travelling in its direction: link 0 pushes to transit 1, link 1 pushes to transit 0.
- A flit that would reverse direction (link 0 with dest < own, or link 1 with dest > own) is discarded, sets ovf_err, and is still acknowledged (lnk_in_rdy=1).
REQ-015 Eject write arbitration: at most one push per cycle. Requesters are link0, link1 and the holding register. Round-robin in that order, with the pointer advancing past the winner. Losers see rdy=0 (link) or keep holding (inject).
REQ-016 Transit write: transit 1 has two possible writers, link 0 and the holding register. They use their own 2-way round-robin; transit 0 is symmetric.
REQ-017 Push happens only when the target count < DEPTH. A pop in the same cycle does not free a slot for a push in that cycle.
REQ-018 lnk_in_rdy[d] = lnk_in_vld[d] & target not full & arbitration won. It may depend combinationally on lnk_in_vld/lnk_in_flit. lnk_out_vld must not depend on lnk_out_rdy.
REQ-019 Output and eject heads:
- lnk_out_vld[d] = transit d non-empty; lnk_out_flit[d] = transit d head. Pop when vld & rdy.
- ej_vld = eject non-empty; ej_* outputs come from the eject head. Pop when ej_vld & ej_rdy.
REQ-020 Occupancy: occ tracks count (push adds 1, pop subtracts 1, push and pop together leave it unchanged). Pointers wrap modulo DEPTH.
REQ-021 Latency: link-in to link-out or to eject is 1 cycle minimum when the target is empty and the arbitration is won. Inject to output is 2 cycles.
REQ-022 ovf_err clears only on reset.

Reset
REQ-030 rst=0, asynchronous, forces the following; FIFO data RAM is not reset.
- All pointers and counts to 0.
- Holding register empty, wrt_stall=0.
- Both round-robin pointers to the link0 position.
- ovf_err=0.
- Every output valid to 0, lnk_in_rdy=0.
REQ-031 Reset asserted mid-transfer drops all stored flits. Operation resumes on the first clk edge after rst deasserts.

Verification
REQ-040 DIM=0, TILE_X=3. Inject tx=5 -> lnk_out_vld[1]=1 two cycles later carrying the same flit; occ transit1 = 1 until lnk_out_rdy[1].
REQ-041 TILE_X=3. lnk_in_vld[0] with tx=3 -> ej_vld=1 next cycle, ej_addr = {TILE_Y,5'd3,addr}; ej_rdy=1 -> occ eject = 0.
REQ-042 Hold lnk_out_rdy[1]=0 and send DEPTH flits with tx=7 on link 0 -> occ transit1 = DEPTH, the next lnk_in_rdy[0]=0, and no overwrite occurs.
REQ-043 link0, link1 and inject all target eject in the same cycle for 3 cycles -> accepted in order link0, link1, inject; each is stalled until its turn.
REQ-044 Inject twice back to back -> the second strobe is dropped and ovf_err=1. A flit on link 1 with tx > TILE_X -> discarded, ovf_err stays 1.
REQ-045 Wrap and reset: push and pop 3*DEPTH flits -> data order is preserved across wrap. Asserting rst with occ nonzero -> occ=0 and all valids 0 immediately, without waiting for a clk edge.
